shift_reg_prog: RTL and testbench
=================================

Name: shift_reg_prog

Overview:
- Multi-channel, run-time programmable delay line. It is the parametrised successor to the fixed-depth channel delay registers in the switch datapath.
- Each of NUB channels carries a WIDTH-bit word plus a valid bit through its own delay of 1..MAX_DELAY enabled clock edges.
- Supports global stall, synchronous flush and per-channel delay reconfiguration.
- Sits between the switch arbiter and the crossbar output stage, where it aligns channel data with grant latency.

Parameters:
- WIDTH, 3, bits per channel word.
- NUB, 3, number of channels.
- MAX_DELAY, 8, number of physical stages per channel; must be >= 1.
- DLY_W, 4, width of one delay field; must satisfy 2**DLY_W > MAX_DELAY.
- DEFAULT_DELAY, 3, active delay of every channel after reset; must be 1..MAX_DELAY.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, advance enable; 0 stalls every stage.
- flush, input, 1, synchronous clear of all valid bits.
- cfg_load, input, 1, single-cycle strobe that samples cfg_delay.
- cfg_delay, input, DLY_W*NUB, per-channel requested delay; channel j uses bits [(j+1)*DLY_W-1 : j*DLY_W].
- in_valid, input, NUB, per-channel input qualifier.
- port_in, input, WIDTH*NUB, channel j uses bits [(j+1)*WIDTH-1 : j*WIDTH].
- out_valid, output, NUB, per-channel output qualifier.
- port_out, output, WIDTH*NUB, delayed data, same packing as port_in.
- cfg_busy, output, 1, high from the first edge after a delay change until every changed channel has refilled.

Behaviour:
- Reset is asynchronous on rst_n low:
  - all stage data and valid bits go to 0;
  - every active delay register goes to DEFAULT_DELAY;
  - out_valid = 0, port_out = 0, cfg_busy = 0.
- Per channel: stage 0 captures {in_valid[j], port_in word j} on a clk edge with en=1. Stage k captures stage k-1. All MAX_DELAY stages shift together.
- Output tap of channel j is stage D_j-1, where D_j is the active delay.
  - out_valid[j] = tap valid.
  - port_out word j = tap data when tap valid = 1, otherwise all zeros.
- Latency: a word sampled with en=1 appears at the output after exactly D_j enabled edges. Disabled edges do not count.
- en=0: stage data and valid bits hold; outputs are stable. flush and cfg_load still act.
- flush=1 at an edge: all valid bits clear, regardless of en; data registers are left untouched. A word presented with in_valid=1 in the same cycle is discarded. Next cycle out_valid = 0.
- cfg_load=1 at an edge: each channel's cfg_delay is clamped and written to D_j. This happens regardless of en.
  - A value greater than MAX_DELAY clamps to MAX_DELAY.
  - A value of 0 clamps to 1, unless the optional feature is enabled.
- On cfg_load, a channel whose clamped delay differs from its current D_j has all its valid bits cleared at that edge. Channels with an unchanged delay are unaffected and keep streaming without a gap.
- cfg_busy:
  - A refill counter loads the largest new delay among the changed channels.
  - The counter decrements on each enabled edge.
  - cfg_busy = (counter != 0).
  - A new cfg_load while busy reloads the counter with max(remaining, new largest changed delay).
  - flush does not affect the counter.
- Simultaneous cfg_load and flush: the delays update and all valid bits clear.
- Simultaneous cfg_load and en=1: stage 0 captures the input at that edge, and that word is timed against the new delay.
- Reset asserted mid-operation: immediate return to the reset state; any in-flight words are lost.

Optional Feature:
- Macro: SHIFT_REG_PROG_ZERO_BYPASS_EN.
- Defined: a requested delay of 0 is legal and stored as 0. For such a channel:
  - out_valid[j] = in_valid[j] & en & ~flush;
  - port_out word j = port_in word j when that valid is 1, else 0;
  - the path is combinational and the stages are ignored.
  - The changed-channel refill for that channel contributes 0 to cfg_busy.
- Not defined: 0 clamps to 1 and no combinational path exists from input to output.

Test Plan:
- Reset, then en=1 with in_valid=3'b111 and channel words 1,2,3 for one cycle -> out_valid=3'b111 and port_out words 1,2,3 on the third edge after input; zeros before and after.
- cfg_load with delays {8,5,1}, stream an incrementing word every cycle -> channel 0 lags by 8, channel 1 by 5, channel 2 by 1; cfg_busy high for 8 enabled edges.
- Stream 0x5 on channel 1 at delay 3, drop en for 4 cycles mid-flight -> output held; the word appears after 3 enabled edges, i.e. 7 cycles total.
- Stream continuously, pulse flush -> out_valid=0 for the next D_j cycles per channel; in-flight words never appear; the word after flush emerges normally.
- cfg_load with cfg_delay channel 0 = 15 and channel 1 unchanged -> channel 0 delay = 8 and its valids cleared; channel 1 output shows no gap.
- With the macro defined, set channel 2 delay to 0 and drive in_valid=1, word 0x7 -> same-cycle out_valid[2]=1 and port_out word 2 = 0x7; with flush=1 -> out_valid[2]=0.

Source files
------------

// File: rtl/shift_reg_prog_if.sv
// Channel bundle between the switch arbiter side and the shift_reg_prog delay line.
// The arbiter drives the master side; the delay line uses the slave side.
interface shift_reg_prog_if #(
  parameter int WIDTH = 3,
  parameter int NUB   = 3,
  parameter int DLY_W = 4
);
  logic                   en;
  logic                   flush;
  logic                   cfg_load;
  logic [DLY_W*NUB-1:0]   cfg_delay;
  logic [NUB-1:0]         in_valid;
  logic [WIDTH*NUB-1:0]   port_in;
  logic [NUB-1:0]         out_valid;
  logic [WIDTH*NUB-1:0]   port_out;
  logic                   cfg_busy;

  modport master (
    output en, flush, cfg_load, cfg_delay, in_valid, port_in,
    input  out_valid, port_out, cfg_busy
  );

  modport slave (
    input  en, flush, cfg_load, cfg_delay, in_valid, port_in,
    output out_valid, port_out, cfg_busy
  );
endinterface

// File: rtl/shift_reg_prog.sv
// Multi-channel delay line with a run-time programmable tap per channel (1..MAX_DELAY edges).
// Optional macro SHIFT_REG_PROG_ZERO_BYPASS_EN allows delay 0 as a combinational pass-through.
module shift_reg_prog #(
  parameter int WIDTH         = 3,
  parameter int NUB           = 3,
  parameter int MAX_DELAY     = 8,
  parameter int DLY_W         = 4,
  parameter int DEFAULT_DELAY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_reg_prog_if.slave bus
);
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);

  logic [DLY_W-1:0]     req_dly [NUB];
  logic                 ch_chg  [NUB];
  logic                 ch_ov   [NUB];
  logic [WIDTH-1:0]     ch_od   [NUB];
  logic [DLY_W-1:0]     max_changed;
  logic [DLY_W-1:0]     cnt_q, cnt_d, cnt_dec;
  logic [NUB-1:0]       out_valid_w;
  logic [WIDTH*NUB-1:0] port_out_w;

  for (genvar gi = 0; gi < NUB; gi++) begin : g_ch
    logic [WIDTH-1:0]     data_q [MAX_DELAY];
    logic [MAX_DELAY-1:0] valid_q, valid_d;
    logic [DLY_W-1:0]     dly_q, raw_w, req_w;
    logic                 tap_v;
    logic [WIDTH-1:0]     tap_d;

    assign raw_w = bus.cfg_delay[gi*DLY_W +: DLY_W];
`ifdef SHIFT_REG_PROG_ZERO_BYPASS_EN
    assign req_w = (raw_w > MAX_D) ? MAX_D : raw_w;
`else
    assign req_w = (raw_w > MAX_D) ? MAX_D : ((raw_w == '0) ? DLY_W'(1) : raw_w);
`endif
    assign req_dly[gi] = req_w;
    assign ch_chg[gi]  = bus.cfg_load && (req_w != dly_q);

    // A changed channel keeps only the word captured on the reconfiguring edge.
    always_comb begin
      valid_d = valid_q;
      if (bus.en)
        valid_d = (valid_q << 1) | MAX_DELAY'(bus.in_valid[gi]);
      if (ch_chg[gi])
        valid_d = MAX_DELAY'(bus.en & bus.in_valid[gi]);
      if (bus.flush)
        valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        dly_q   <= DLY_W'(DEFAULT_DELAY);
        for (int k = 0; k < MAX_DELAY; k++)
          data_q[k] <= '0;
      end else begin
        valid_q <= valid_d;
        if (bus.cfg_load)
          dly_q <= req_w;
        if (bus.en) begin
          data_q[0] <= bus.port_in[gi*WIDTH +: WIDTH];
          for (int k = 1; k < MAX_DELAY; k++)
            data_q[k] <= data_q[k-1];
        end
      end
    end

    always_comb begin
      tap_v = 1'b0;
      tap_d = '0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        if (dly_q == DLY_W'(k + 1)) begin
          tap_v = valid_q[k];
          tap_d = data_q[k];
        end
      end
`ifdef SHIFT_REG_PROG_ZERO_BYPASS_EN
      if (dly_q == '0) begin
        tap_v = bus.in_valid[gi] & bus.en & ~bus.flush;
        tap_d = bus.port_in[gi*WIDTH +: WIDTH];
      end
`endif
    end

    assign ch_ov[gi] = tap_v;
    assign ch_od[gi] = tap_v ? tap_d : '0;
  end

  // Refill counter tracks the slowest changed channel; a bypass channel adds 0.
  always_comb begin
    max_changed = '0;
    for (int j = 0; j < NUB; j++)
      if (ch_chg[j] && (req_dly[j] > max_changed))
        max_changed = req_dly[j];
    cnt_dec = (bus.en && (cnt_q != '0)) ? cnt_q - DLY_W'(1) : cnt_q;
    cnt_d   = cnt_dec;
    if (bus.cfg_load && (max_changed > cnt_dec))
      cnt_d = max_changed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    out_valid_w = '0;
    port_out_w  = '0;
    for (int j = 0; j < NUB; j++) begin
      out_valid_w[j]                = ch_ov[j];
      port_out_w[j*WIDTH +: WIDTH]  = ch_od[j];
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.port_out  = port_out_w;
  assign bus.cfg_busy  = (cnt_q != '0);
endmodule

// File: tb/tb_shift_reg_prog.sv
// Self-checking bench for shift_reg_prog: table vectors, directed corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_shift_reg_prog;
  localparam int WIDTH = 3, NUB = 3, MAX_DELAY = 8, DLY_W = 4, DEFAULT_DELAY = 3;
  localparam int RING = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  shift_reg_prog_if #(.WIDTH(WIDTH), .NUB(NUB), .DLY_W(DLY_W)) bus_if ();

  shift_reg_prog #(
    .WIDTH(WIDTH), .NUB(NUB), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W), .DEFAULT_DELAY(DEFAULT_DELAY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: every enabled edge gets a timestamp; a channel's output is the word
  // stamped D edges ago, unless a flush/reconfiguration killed everything up to a stamp.
  int               ecnt;
  int               target;
  int               kill_ts [NUB];
  int               dm      [NUB];
  logic             mv      [NUB][RING];
  logic [WIDTH-1:0] md      [NUB][RING];

  logic [NUB-1:0]       obs_ov;
  logic [WIDTH*NUB-1:0] obs_po;
  logic                 obs_busy;

  typedef struct {
    logic                 en;
    logic [NUB-1:0]       iv;
    logic [WIDTH*NUB-1:0] pin;
    logic [NUB-1:0]       exp_ov;
    logic [WIDTH*NUB-1:0] exp_po;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int clampd(input int r);
    if (r > MAX_DELAY) return MAX_DELAY;
`ifdef SHIFT_REG_PROG_ZERO_BYPASS_EN
    return r;
`else
    return (r == 0) ? 1 : r;
`endif
  endfunction

  function automatic logic [WIDTH*NUB-1:0] pack3(input int w);
    logic [WIDTH*NUB-1:0] p;
    for (int j = 0; j < NUB; j++)
      p[j*WIDTH +: WIDTH] = WIDTH'(w + j);
    return p;
  endfunction

  task automatic model_reset();
    ecnt   = 0;
    target = 0;
    for (int j = 0; j < NUB; j++) begin
      kill_ts[j] = 0;
      dm[j]      = DEFAULT_DELAY;
      for (int r = 0; r < RING; r++) begin
        mv[j][r] = 1'b0;
        md[j][r] = '0;
      end
    end
  endtask

  task automatic model_edge();
    int maxc;
    int c;
    maxc = 0;
    if (bus_if.en) begin
      ecnt++;
      for (int j = 0; j < NUB; j++) begin
        mv[j][ecnt % RING] = bus_if.in_valid[j];
        md[j][ecnt % RING] = bus_if.port_in[j*WIDTH +: WIDTH];
      end
    end
    if (bus_if.flush)
      for (int j = 0; j < NUB; j++) kill_ts[j] = ecnt;
    if (bus_if.cfg_load) begin
      for (int j = 0; j < NUB; j++) begin
        c = clampd(int'(bus_if.cfg_delay[j*DLY_W +: DLY_W]));
        if (c != dm[j]) begin
          if (bus_if.en && !bus_if.flush) begin
            if (ecnt - 1 > kill_ts[j]) kill_ts[j] = ecnt - 1;
          end else begin
            kill_ts[j] = ecnt;
          end
          if (c > maxc) maxc = c;
          dm[j] = c;
        end
      end
      if (ecnt + maxc > target) target = ecnt + maxc;
    end
  endtask

  task automatic model_expect(output logic [NUB-1:0] ov, output logic [WIDTH*NUB-1:0] po,
                              output logic busy);
    ov = '0;
    po = '0;
    for (int j = 0; j < NUB; j++) begin
      logic v;
      logic [WIDTH-1:0] d;
      int ts;
      v = 1'b0;
      d = '0;
      if (dm[j] == 0) begin
        v = bus_if.in_valid[j] & bus_if.en & ~bus_if.flush;
        d = bus_if.port_in[j*WIDTH +: WIDTH];
      end else begin
        ts = ecnt - dm[j] + 1;
        if (ts >= 1 && ts > kill_ts[j]) begin
          v = mv[j][ts % RING];
          d = md[j][ts % RING];
        end
      end
      ov[j] = v;
      po[j*WIDTH +: WIDTH] = v ? d : '0;
    end
    busy = (target > ecnt);
  endtask

  // Called at posedge+1: drive, compare at the falling edge, advance one clock.
  task automatic cycle(input logic en, input logic fl, input logic ld,
                       input logic [DLY_W*NUB-1:0] cfg, input logic [NUB-1:0] iv,
                       input logic [WIDTH*NUB-1:0] pin, input string tag);
    logic [NUB-1:0]       eov;
    logic [WIDTH*NUB-1:0] epo;
    logic                 eb;
    bus_if.en        = en;
    bus_if.flush     = fl;
    bus_if.cfg_load  = ld;
    bus_if.cfg_delay = cfg;
    bus_if.in_valid  = iv;
    bus_if.port_in   = pin;
    #4;
    model_expect(eov, epo, eb);
    obs_ov   = bus_if.out_valid;
    obs_po   = bus_if.port_out;
    obs_busy = bus_if.cfg_busy;
    $display("%s: en=%0b fl=%0b ld=%0b cfg=%h iv=%b in=%h | ov=%b out=%h busy=%0b",
             tag, en, fl, ld, cfg, iv, pin, obs_ov, obs_po, obs_busy);
    chk({tag, " out_valid"}, 32'(obs_ov), 32'(eov));
    chk({tag, " port_out"},  32'(obs_po), 32'(epo));
    chk({tag, " cfg_busy"},  32'(obs_busy), 32'(eb));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    int w;
    int busy_cnt;
    int first;
    int zeros;
    int gaps;
    logic [WIDTH-1:0] first_word;
    logic [WIDTH*NUB-1:0] post_flush_word;

    bus_if.en = 1'b0; bus_if.flush = 1'b0; bus_if.cfg_load = 1'b0;
    bus_if.cfg_delay = '0; bus_if.in_valid = '0; bus_if.port_in = '0;
    model_reset();

    #3;
    chk("reset out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("reset port_out",  32'(bus_if.port_out),  32'h0);
    chk("reset cfg_busy",  32'(bus_if.cfg_busy),  32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single burst at the default delay of 3: visible only on the third edge.
    tbl[0] = '{1'b1, 3'b111, 9'o321, 3'b000, 9'o000};
    tbl[1] = '{1'b1, 3'b000, 9'o000, 3'b000, 9'o000};
    tbl[2] = '{1'b1, 3'b000, 9'o000, 3'b000, 9'o000};
    tbl[3] = '{1'b1, 3'b000, 9'o000, 3'b111, 9'o321};
    tbl[4] = '{1'b1, 3'b000, 9'o000, 3'b000, 9'o000};
    tbl[5] = '{1'b1, 3'b000, 9'o000, 3'b000, 9'o000};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].en, 1'b0, 1'b0, '0, tbl[i].iv, tbl[i].pin, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d exp out_valid", i), 32'(obs_ov), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d exp port_out", i),  32'(obs_po), 32'(tbl[i].exp_po));
    end

    // Delays {8,5,1} on channels 0,1,2 with a streaming count.
    w = 0;
    cycle(1'b1, 1'b0, 1'b1, 12'h158, 3'b111, pack3(w), "cfg158");
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      w++;
      cycle(1'b1, 1'b0, 1'b0, '0, 3'b111, pack3(w), "stream");
      if (obs_busy) busy_cnt++;
    end
    chk("busy enabled edges", 32'(busy_cnt), 32'd8);

    // Back to delay 3 everywhere, let it drain.
    cycle(1'b1, 1'b0, 1'b1, 12'h333, 3'b000, '0, "cfg333");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, '0, 3'b000, '0, "drain");

    // Word 5 on channel 1 with a 4-cycle stall in flight.
    cycle(1'b1, 1'b0, 1'b0, '0, 3'b010, 9'o050, "stall_in");
    first = -1;
    first_word = '0;
    for (int k = 1; k <= 9; k++) begin
      cycle((k >= 2 && k <= 5) ? 1'b0 : 1'b1, 1'b0, 1'b0, '0, 3'b000, '0, "stall");
      if (obs_ov[1] && first < 0) begin
        first = k;
        first_word = obs_po[WIDTH +: WIDTH];
      end
    end
    chk("stall latency", 32'(first), 32'd7);
    chk("stall word", 32'(first_word), 32'd5);

    // Flush in the middle of a stream.
    for (int i = 0; i < 5; i++) begin w++; cycle(1'b1, 1'b0, 1'b0, '0, 3'b111, pack3(w), "pre_flush"); end
    w++;
    cycle(1'b1, 1'b1, 1'b0, '0, 3'b111, pack3(w), "flush");
    zeros = 0;
    first = -1;
    post_flush_word = '0;
    for (int k = 1; k <= 6; k++) begin
      w++;
      if (k == 1) post_flush_word = pack3(w);
      cycle(1'b1, 1'b0, 1'b0, '0, 3'b111, pack3(w), "post_flush");
      if (first < 0) begin
        if (obs_ov == 3'b000) zeros++;
        else begin
          first = k;
          chk("post flush word", 32'(obs_po), 32'(post_flush_word));
        end
      end
    end
    chk("flush quiet cycles", 32'(zeros), 32'd3);

    // Channel 0 asks for 15 (clamps to 8); channels 1,2 unchanged keep streaming.
    w++;
    cycle(1'b1, 1'b0, 1'b1, 12'h33F, 3'b111, pack3(w), "cfg33F");
    gaps = 0;
    for (int k = 1; k <= 10; k++) begin
      w++;
      cycle(1'b1, 1'b0, 1'b0, '0, 3'b111, pack3(w), "no_gap");
      if (k == 1) begin
        chk("clamp ch0 cleared", 32'(obs_ov[0]), 32'd0);
        chk("clamp busy", 32'(obs_busy), 32'd1);
      end
      if (!obs_ov[1]) gaps++;
    end
    chk("ch1 gaps", 32'(gaps), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
            (DLY_W*NUB)'($urandom), (NUB)'($urandom), (WIDTH*NUB)'($urandom), "rand");
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 4; i++) begin w++; cycle(1'b1, 1'b0, 1'b0, '0, 3'b111, pack3(w), "pre_rst"); end
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("mid reset port_out",  32'(bus_if.port_out),  32'h0);
    chk("mid reset cfg_busy",  32'(bus_if.cfg_busy),  32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, '0, 3'b101, 9'o604, "post_rst");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0, 3'b000, '0, "post_rst");

`ifdef SHIFT_REG_PROG_ZERO_BYPASS_EN
    cycle(1'b1, 1'b0, 1'b1, 12'h033, 3'b000, '0, "cfg033");
    cycle(1'b1, 1'b0, 1'b0, '0, 3'b100, 9'o700, "bypass");
    chk("bypass valid", 32'(obs_ov[2]), 32'd1);
    chk("bypass word", 32'(obs_po[2*WIDTH +: WIDTH]), 32'd7);
    cycle(1'b1, 1'b1, 1'b0, '0, 3'b100, 9'o700, "bypass_flush");
    chk("bypass flush valid", 32'(obs_ov[2]), 32'd0);
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 5) != 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            (DLY_W*NUB)'($urandom_range(0, 3)), (NUB)'($urandom), (WIDTH*NUB)'($urandom), "brand");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
